// File: rtl/button_conditioner.sv
// Two-channel push-button front end: pad synchroniser, stability-counter debounce,
// clean level plus a one-cycle press strobe. Define AUTO_REPEAT_EN to add held-button repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 360000,
  parameter int CNT_W           = 19,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int REPEAT_DELAY    = 18000000,
  parameter int REPEAT_PERIOD   = 5400000,
  parameter int RPT_W           = 25
) (
  input  logic i_clk_36MHz,
  input  logic i_reset,
  input  logic i_btn_left_raw,
  input  logic i_btn_right_raw,
  output logic o_left_level,
  output logic o_right_level,
  output logic o_left_pulse,
  output logic o_right_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic             RELEASED = BTN_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) ||
      ((longint'(1) << RPT_W) <= longint'(REPEAT_DELAY)) ||
      ((longint'(1) << RPT_W) <= longint'(REPEAT_PERIOD))) begin : g_bad_cfg
    $error("button_conditioner: counter width too small for its limit");
  end

  logic [1:0] raw;
  logic [1:0] fire;
  logic [1:0] level;
  logic [1:0] pulse_q, pulse_d;

  assign raw = {i_btn_right_raw, i_btn_left_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             qualify;

    always_ff @(posedge i_clk_36MHz) begin
      if (!i_reset) begin
        sync1_q <= RELEASED;
        sync2_q <= RELEASED;
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        sync1_q <= raw[ch];
        sync2_q <= sync1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    // s is 1 while pressed, whatever the pad polarity
    assign s = sync2_q ^ RELEASED;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      qualify = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = HELD;
              level_d = 1'b1;
              qualify = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            level_d = 1'b1;
            qualify = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = IDLE;
              level_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             rpt_fire;

    always_ff @(posedge i_clk_36MHz) begin
      if (!i_reset) begin
        rpt_q       <= '0;
        rpt_phase_q <= 1'b0;
      end else begin
        rpt_q       <= rpt_d;
        rpt_phase_q <= rpt_phase_d;
      end
    end

    // phase 0 waits out the initial delay, phase 1 runs the repeat period
    always_comb begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
      rpt_fire    = 1'b0;
      if (state_q == HELD && s) begin
        if (rpt_q == (rpt_phase_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
          rpt_fire    = 1'b1;
          rpt_phase_d = 1'b1;
        end else begin
          rpt_d       = rpt_q + RPT_W'(1);
          rpt_phase_d = rpt_phase_q;
        end
      end
    end

    assign fire[ch] = qualify | rpt_fire;
`else
    assign fire[ch] = qualify;
`endif

    assign level[ch] = level_q;
  end

  // left wins when both channels strobe in the same cycle
  always_comb begin
    pulse_d[0] = fire[0];
    pulse_d[1] = fire[1] & ~fire[0];
  end

  always_ff @(posedge i_clk_36MHz) begin
    if (!i_reset) pulse_q <= '0;
    else          pulse_q <= pulse_d;
  end

  assign o_left_level  = level[0];
  assign o_right_level = level[1];
  assign o_left_pulse  = pulse_q[0];
  assign o_right_pulse = pulse_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/repeat constants and active-low pads.
module tb_button_conditioner;

  typedef struct {
    logic l;
    logic r;
    int   hold;
    int   lp;
    int   rp;
    logic ll;
    logic rl;
  } vec_t;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pad_l = 1'b1;
  logic pad_r = 1'b1;
  logic left_level, right_level, left_pulse, right_pulse;

  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  ev_t  sb[$];
  vec_t vecs[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .BTN_ACTIVE_LOW (1'b1),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (10),
    .RPT_W          (8)
  ) dut (
    .i_clk_36MHz    (clk),
    .i_reset        (rst_n),
    .i_btn_left_raw (pad_l),
    .i_btn_right_raw(pad_r),
    .o_left_level   (left_level),
    .o_right_level  (right_level),
    .o_left_pulse   (left_pulse),
    .o_right_pulse  (right_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      $display("FAIL pulse_missing: got no pulse at cycle %0d, expected l=%0d r=%0d",
               sb[0].cyc, sb[0].l, sb[0].r);
      sb.delete(0);
    end
    if (left_pulse || right_pulse) begin
      total++;
      if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].l == left_pulse && sb[0].r == right_pulse) begin
        passed++;
        sb.delete(0);
      end else begin
        $display("FAIL pulse_unexpected: got l=%0d r=%0d at cycle %0d, expected no such pulse",
                 left_pulse, right_pulse, cyc);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic expect_pulse(input int off, input logic l, input logic r);
    ev_t e;
    e.cyc = cyc + off;
    e.l   = l;
    e.r   = r;
    sb.push_back(e);
  endtask

  task automatic add(input logic l, input logic r, input int hold, input int lp, input int rp,
                     input logic ll, input logic rl);
    vec_t v;
    v.l = l; v.r = r; v.hold = hold; v.lp = lp; v.rp = rp; v.ll = ll; v.rl = rl;
    vecs.push_back(v);
  endtask

  initial begin
    // pad, pad, hold, left pulse offset, right pulse offset, expected levels after hold
    add(1'b0, 1'b1,  9, 10, -1, 1'b0, 1'b0);  // one cycle short of acceptance
    add(1'b0, 1'b1,  1, -1, -1, 1'b1, 1'b0);  // level rises with the pulse
    add(1'b0, 1'b1, 20, -1, -1, 1'b1, 1'b0);
    add(1'b1, 1'b1,  9, -1, -1, 1'b1, 1'b0);  // release still pending
    add(1'b1, 1'b1,  1, -1, -1, 1'b0, 1'b0);  // release accepted, no pulse
    add(1'b1, 1'b0, 10, -1, 10, 1'b0, 1'b1);
    add(1'b0, 1'b1, 10, 10, -1, 1'b1, 1'b0);  // swap channels on one edge
    add(1'b1, 1'b1, 12, -1, -1, 1'b0, 1'b0);
    add(1'b0, 1'b1,  7, -1, -1, 1'b0, 1'b0);  // 7-cycle press rejected
    add(1'b1, 1'b1, 12, -1, -1, 1'b0, 1'b0);
    add(1'b0, 1'b1,  8, 10, -1, 1'b0, 1'b0);  // 8-cycle press accepted
    add(1'b1, 1'b1, 12, -1, -1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 12, 10, -1, 1'b1, 1'b0);
    add(1'b1, 1'b1,  7, -1, -1, 1'b1, 1'b0);  // release glitch ignored
    add(1'b0, 1'b1, 12, -1, -1, 1'b1, 1'b0);  // back to held, no pulse
    add(1'b1, 1'b1, 12, -1, -1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 10, 10, -1, 1'b1, 1'b1);  // simultaneous: left pulse only
    add(1'b1, 1'b1, 12, -1, -1, 1'b0, 1'b0);

    // reset with pads released
    tick(3);
    chk("reset_left_level",  int'(left_level),  0);
    chk("reset_right_level", int'(right_level), 0);
    chk("reset_left_pulse",  int'(left_pulse),  0);
    chk("reset_right_pulse", int'(right_pulse), 0);
    rst_n = 1'b1;
    tick(50);
    chk("idle_left_level",  int'(left_level),  0);
    chk("idle_right_level", int'(right_level), 0);

    foreach (vecs[i]) begin
      pad_l = vecs[i].l;
      pad_r = vecs[i].r;
      if (vecs[i].lp >= 0) expect_pulse(vecs[i].lp, 1'b1, 1'b0);
      if (vecs[i].rp >= 0) expect_pulse(vecs[i].rp, 1'b0, 1'b1);
      tick(vecs[i].hold);
      chk($sformatf("vec%0d_left_level", i),  int'(left_level),  int'(vecs[i].ll));
      chk($sformatf("vec%0d_right_level", i), int'(right_level), int'(vecs[i].rl));
    end

    // bouncing pad: toggles every 3 cycles, then settles pressed
    for (int i = 0; i < 20; i++) begin
      pad_l = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    chk("bounce_no_level", int'(left_level), 0);
    pad_l = 1'b0;
    expect_pulse(10, 1'b1, 1'b0);
    tick(12);
    chk("bounce_settled_level", int'(left_level), 1);
    pad_l = 1'b1;
    tick(12);
    chk("bounce_release_level", int'(left_level), 0);

    // reset while held, pad kept pressed through and after reset
    pad_l = 1'b0;
    expect_pulse(10, 1'b1, 1'b0);
    tick(15);
    chk("pre_reset_level", int'(left_level), 1);
    rst_n = 1'b0;
    tick(1);
    chk("mid_reset_level", int'(left_level), 0);
    chk("mid_reset_pulse", int'(left_pulse), 0);
    tick(2);
    rst_n = 1'b1;
    expect_pulse(10, 1'b1, 1'b0);
    tick(9);
    chk("requal_level_early", int'(left_level), 0);
    tick(1);
    chk("requal_level", int'(left_level), 1);
    pad_l = 1'b1;
    tick(12);
    chk("requal_release_level", int'(left_level), 0);

    // long hold on the right pad
    pad_r = 1'b0;
    expect_pulse(10, 1'b0, 1'b1);
`ifdef AUTO_REPEAT_EN
    expect_pulse(50, 1'b0, 1'b1);
    expect_pulse(60, 1'b0, 1'b1);
    expect_pulse(70, 1'b0, 1'b1);
`endif
    tick(72);
    chk("long_hold_level", int'(right_level), 1);
    pad_r = 1'b1;
    tick(15);
    chk("long_hold_release_level", int'(right_level), 0);

    while (sb.size() > 0) begin
      total++;
      $display("FAIL pulse_missing: got no pulse by cycle %0d, expected one at cycle %0d",
               cyc, sb[0].cyc);
      sb.delete(0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
